// File: rtl/debounce2.sv
// Two-channel push-button debouncer: 2-FF synchronizer plus a 4-state stability FSM per channel.
// Optional single-cycle edge pulses are compiled in when DEBOUNCE2_EDGE_PULSE_EN is defined.
module debounce2 #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_clean,
    output logic b_clean
`ifdef DEBOUNCE2_EDGE_PULSE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0] raw_s;
    logic [1:0] clean_s;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
    logic [1:0] rise_s;
    logic [1:0] fall_s;
`endif

    assign raw_s = {b_raw, a_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic                 sync1_q;
        logic                 sync2_q;
        state_t               state_q;
        state_t               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 clean_q;
        logic                 clean_d;

        // Two-flop synchronizer for the asynchronous raw input.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= raw_s[ch];
                sync2_q <= sync1_q;
            end
        end

        // State, stability counter and registered clean level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE_LOW;
                cnt_q   <= {CNT_WIDTH{1'b0}};
                clean_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
            end
        end

        // Next-state logic; any reversal while waiting drops back to the idle state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE_LOW: begin
                    if (sync2_q) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_d = IDLE_LOW;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q) begin
                        state_d = IDLE_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2_q) begin
                        state_d = WAIT_LOW;
                        cnt_d   = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_d = IDLE_HIGH;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q) begin
                        state_d = IDLE_HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = {CNT_WIDTH{1'b0}};
                end
            endcase
            clean_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
        end

        assign clean_s[ch] = clean_q;

`ifdef DEBOUNCE2_EDGE_PULSE_EN
        logic rise_q;
        logic fall_q;

        // Edge pulses share the clean register's update so they align with its first new cycle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= clean_d & ~clean_q;
                fall_q <= ~clean_d & clean_q;
            end
        end

        assign rise_s[ch] = rise_q;
        assign fall_s[ch] = fall_q;
`endif
    end

    assign a_clean = clean_s[0];
    assign b_clean = clean_s[1];
`ifdef DEBOUNCE2_EDGE_PULSE_EN
    assign a_rise  = rise_s[0];
    assign a_fall  = fall_s[0];
    assign b_rise  = rise_s[1];
    assign b_fall  = fall_s[1];
`endif

endmodule

// File: tb/tb_debounce2.sv
// Self-checking bench for debounce2 (STABLE_CYCLES=4, CNT_WIDTH=3); edge-pulse checks follow
// DEBOUNCE2_EDGE_PULSE_EN. A run-length reference model feeds a per-cycle scoreboard queue.
module tb_debounce2;

    localparam int STABLE = 4;

    logic clk;
    logic reset;
    logic a_raw;
    logic b_raw;
    logic a_clean;
    logic b_clean;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
`endif

    int checks = 0;
    int errors = 0;

    // expected vector: {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall}
    logic [5:0] sb_q[$];

    bit m_p1[2];
    bit m_p2[2];
    bit m_clean[2];
    int m_run[2];

    debounce2 #(
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_clean(a_clean),
        .b_clean(b_clean)
`ifdef DEBOUNCE2_EDGE_PULSE_EN
        ,
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_p1[ch]    = 1'b0;
            m_p2[ch]    = 1'b0;
            m_clean[ch] = 1'b0;
            m_run[ch]   = 0;
        end
    endtask

    // Reference: the level flips once the synchronized input has disagreed with it for STABLE+1 edges.
    task automatic model_edge(output logic [5:0] exp);
        bit raw[2];
        bit rise[2];
        bit fall[2];
        raw[0] = a_raw;
        raw[1] = b_raw;
        for (int ch = 0; ch < 2; ch++) begin
            rise[ch] = 1'b0;
            fall[ch] = 1'b0;
            if (m_p2[ch] != m_clean[ch]) begin
                m_run[ch] = m_run[ch] + 1;
                if (m_run[ch] == STABLE + 1) begin
                    m_clean[ch] = ~m_clean[ch];
                    m_run[ch]   = 0;
                    rise[ch]    = m_clean[ch];
                    fall[ch]    = ~m_clean[ch];
                end
            end else begin
                m_run[ch] = 0;
            end
            m_p2[ch] = m_p1[ch];
            m_p1[ch] = raw[ch];
        end
        exp = {m_clean[0], m_clean[1], rise[0], fall[0], rise[1], fall[1]};
    endtask

    task automatic tick();
        logic [5:0] exp;
        model_edge(exp);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop the expectation for the last edge and compare on the falling edge.
    always @(negedge clk) begin
        logic [5:0] exp;
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            checks++;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if ({a_clean, b_clean, a_rise, a_fall, b_rise, b_fall} !== exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t got=%b want=%b", $time,
                         {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall}, exp);
            end
`else
            if ({a_clean, b_clean} !== exp[5:4]) begin
                errors++;
                $display("FAIL scoreboard t=%0t got=%b want=%b", $time, {a_clean, b_clean}, exp[5:4]);
            end
`endif
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({a_clean, b_clean} !== 2'b00) begin
            errors++;
            $display("FAIL reset_clean got=%b want=00", {a_clean, b_clean});
        end
`ifdef DEBOUNCE2_EDGE_PULSE_EN
        checks++;
        if ({a_rise, a_fall, b_rise, b_fall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got=%b want=0000", {a_rise, a_fall, b_rise, b_fall});
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        int rise_at = -1;
        int fall_at = -1;
        int nrise = 0;
        a_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_clean === 1'b1 && rise_at < 0) rise_at = k;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if (a_rise === 1'b1) nrise++;
`endif
        end
        checks++;
        if (rise_at !== 6) begin
            errors++;
            $display("FAIL press_latency got=%0d want=6", rise_at);
        end
`ifdef DEBOUNCE2_EDGE_PULSE_EN
        checks++;
        if (nrise !== 1) begin
            errors++;
            $display("FAIL press_rise_count got=%0d want=1", nrise);
        end
`endif
        a_raw = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (a_clean === 1'b0 && fall_at < 0) fall_at = k;
        end
        checks++;
        if (fall_at !== 6) begin
            errors++;
            $display("FAIL release_latency got=%0d want=6", fall_at);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern = 8'b0011_0011;
        int rise_at = -1;
        int nrise = 0;
        for (int k = 0; k < 8; k++) begin
            a_raw = pattern[k];
            tick();
            if (a_clean !== 1'b0) rise_at = 100;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if (a_rise === 1'b1) nrise++;
`endif
        end
        a_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_clean === 1'b1 && rise_at < 0) rise_at = k;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if (a_rise === 1'b1) nrise++;
`endif
        end
        checks++;
        if (rise_at !== 6) begin
            errors++;
            $display("FAIL bounce_latency got=%0d want=6", rise_at);
        end
`ifdef DEBOUNCE2_EDGE_PULSE_EN
        checks++;
        if (nrise !== 1) begin
            errors++;
            $display("FAIL bounce_rise_count got=%0d want=1", nrise);
        end
`endif
        a_raw = 1'b0;
        repeat (9) tick();
    endtask

    task automatic test_glitch();
        int seen = 0;
        b_raw = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) b_raw = 1'b0;
            tick();
            if (b_clean !== 1'b0) seen++;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if (b_rise !== 1'b0 || b_fall !== 1'b0) seen++;
`endif
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL glitch_reject got=%0d activity want=0", seen);
        end
    endtask

    task automatic test_simultaneous_release();
        int a_at = -1;
        int b_at = -1;
        int af_at = -1;
        int bf_at = -1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (8) tick();
        checks++;
        if ({a_clean, b_clean} !== 2'b11) begin
            errors++;
            $display("FAIL both_high got=%b want=11", {a_clean, b_clean});
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (a_clean === 1'b0 && a_at < 0) a_at = k;
            if (b_clean === 1'b0 && b_at < 0) b_at = k;
`ifdef DEBOUNCE2_EDGE_PULSE_EN
            if (a_fall === 1'b1) af_at = k;
            if (b_fall === 1'b1) bf_at = k;
`else
            af_at = a_at;
            bf_at = b_at;
`endif
        end
        checks++;
        if (a_at !== 6 || b_at !== 6) begin
            errors++;
            $display("FAIL simul_clean_fall got a=%0d b=%0d want 6 6", a_at, b_at);
        end
        checks++;
        if (af_at !== 6 || bf_at !== 6) begin
            errors++;
            $display("FAIL simul_fall_pulse got a=%0d b=%0d want 6 6", af_at, bf_at);
        end
    endtask

    task automatic test_reset_mid_wait();
        int a_at = -1;
        int b_at = -1;
        b_raw = 1'b1;
        repeat (8) tick();
        a_raw = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({a_clean, b_clean} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_clean got=%b want=00", {a_clean, b_clean});
        end
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_clean === 1'b1 && a_at < 0) a_at = k + 1;
            if (b_clean === 1'b1 && b_at < 0) b_at = k + 1;
        end
        checks++;
        if (a_at !== 7 || b_at !== 7) begin
            errors++;
            $display("FAIL post_reset_edges got a=%0d b=%0d want 7 7", a_at, b_at);
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (9) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous_release();
        test_reset_mid_wait();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
